// File: rtl/derivative_lut_mc.sv
// Shared, runtime-writable surrogate-derivative table serving NUM_CH lanes via round-robin grant.
// Latency: 2 cycles from handshake to rsp_valid; one lookup per cycle.
// Backpressure: table writes block all grants; no response backpressure, responses in grant order.
module derivative_lut_mc #(
   parameter  int DATA_WIDTH = 9,
   parameter  int ADDR_WIDTH = 8,
   parameter  int NUM_CH     = 4,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_we,
   input  logic [ADDR_WIDTH-1:0]        cfg_addr,
   input  logic [DATA_WIDTH-1:0]        cfg_wdata,
   input  logic [NUM_CH-1:0]            req_valid,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CH-1:0]            req_neg,
   output logic [NUM_CH-1:0]            req_ready,
   output logic                         rsp_valid,
   output logic [CH_W-1:0]              rsp_ch,
   output logic [DATA_WIDTH-1:0]        rsp_data,
   output logic                         rsp_sat
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] SMAX = ~SMIN;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [CH_W-1:0]       ptr_q, ptr_d;
   logic [CH_W-1:0]       gnt_idx;
   logic                  gnt_found;
   logic                  hs;

   logic                  s1_vld_q;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic [CH_W-1:0]       s1_ch_q;
   logic                  s1_neg_q, s1_neg_d;

   logic [DATA_WIDTH-1:0] rd_dat;
   logic [DATA_WIDTH-1:0] rsp_dat_d;
   logic                  rsp_sat_d;

   logic                  rsp_vld_q;
   logic [CH_W-1:0]       rsp_ch_q;
   logic [DATA_WIDTH-1:0] rsp_dat_q;
   logic                  rsp_sat_q;

   // Round-robin search starting one past the last winner; writes and reset suppress every grant.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      req_ready = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(ptr_q) + k) % NUM_CH;
         if (!gnt_found && req_valid[CH_W'(idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(idx);
         end
      end
      if (gnt_found && rst_n && !cfg_we) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign hs        = |(req_valid & req_ready);
   assign ptr_d     = hs ? gnt_idx : ptr_q;
   assign s1_addr_d = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign s1_neg_d  = req_neg[gnt_idx];

   // Table storage: cleared by reset, written one entry per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (cfg_we) begin
         mem_q[cfg_addr] <= cfg_wdata;
      end
   end

   // Arbiter pointer and stage-1 request capture; pointer resets so lane 0 wins first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q     <= CH_W'(NUM_CH - 1);
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_ch_q   <= '0;
         s1_neg_q  <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         s1_vld_q <= hs;
         if (hs) begin
            s1_addr_q <= s1_addr_d;
            s1_ch_q   <= gnt_idx;
            s1_neg_q  <= s1_neg_d;
         end
      end
   end

   // Write-first read of the stage-1 address, then optional saturating negation.
   always_comb begin
      rd_dat    = (cfg_we && (cfg_addr == s1_addr_q)) ? cfg_wdata : mem_q[s1_addr_q];
      rsp_dat_d = rd_dat;
      rsp_sat_d = 1'b0;
      if (s1_neg_q) begin
         if (rd_dat == SMIN) begin
            rsp_dat_d = SMAX;
            rsp_sat_d = 1'b1;
         end else begin
            rsp_dat_d = -rd_dat;
         end
      end
   end

   // Output registers; payload holds its last value between responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_vld_q <= 1'b0;
         rsp_ch_q  <= '0;
         rsp_dat_q <= '0;
         rsp_sat_q <= 1'b0;
      end else begin
         rsp_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            rsp_ch_q  <= s1_ch_q;
            rsp_dat_q <= rsp_dat_d;
            rsp_sat_q <= rsp_sat_d;
         end
      end
   end

   assign rsp_valid = rsp_vld_q;
   assign rsp_ch    = rsp_ch_q;
   assign rsp_data  = rsp_dat_q;
   assign rsp_sat   = rsp_sat_q;

endmodule

// File: tb/tb_derivative_lut_mc.sv
// Bench for derivative_lut_mc: directed steps then random traffic against a table/queue reference model.
// Expected responses are resolved from the model table at the read cycle, after that cycle's write.
// Inputs change 1 time unit after posedge; outputs are compared at negedge or 1 unit after posedge.
module tb_derivative_lut_mc;

   localparam int DW = 9;
   localparam int AW = 8;
   localparam int NC = 4;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           cfg_we;
   logic [AW-1:0]  cfg_addr;
   logic [DW-1:0]  cfg_wdata;
   logic [NC-1:0]  req_valid;
   logic [NC*AW-1:0] req_addr;
   logic [NC-1:0]  req_neg;
   logic [NC-1:0]  req_ready;
   logic           rsp_valid;
   logic [CW-1:0]  rsp_ch;
   logic [DW-1:0]  rsp_data;
   logic           rsp_sat;

   always #5 clk = ~clk;

   derivative_lut_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .req_valid(req_valid), .req_addr(req_addr), .req_neg(req_neg), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_sat(rsp_sat)
   );

   typedef struct {int ch; int addr; int neg; int due;} pend_t;

   int checks = 0;
   int errors = 0;
   int tbl [256];
   int ptr;
   int cyc;
   pend_t pend [$];
   int ev_vld, ev_ch, ev_data, ev_sat;
   logic [NC-1:0] last_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first requesting lane after the last winner, none during write or reset.
   function automatic logic [NC-1:0] model_grant();
      logic [NC-1:0] g;
      g = '0;
      if (rst_n === 1'b1 && cfg_we === 1'b0) begin
         for (int k = 1; k <= NC; k++) begin
            int i;
            i = (ptr + k) % NC;
            if (req_valid[i] === 1'b1) begin
               g[i] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   task automatic model_step(input logic [NC-1:0] g);
      pend_t p;
      int v;
      if (rst_n !== 1'b1) begin
         foreach (tbl[i]) tbl[i] = 0;
         pend.delete();
         ev_vld = 0; ev_ch = 0; ev_data = 0; ev_sat = 0;
         ptr = NC - 1;
      end else begin
         if (cfg_we === 1'b1) tbl[cfg_addr] = int'(cfg_wdata);
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            p = pend.pop_front();
            v = tbl[p.addr];
            ev_vld = 1;
            ev_ch  = p.ch;
            if (p.neg == 0) begin
               ev_data = v; ev_sat = 0;
            end else if (v == 256) begin
               ev_data = 255; ev_sat = 1;
            end else begin
               ev_data = (512 - v) % 512; ev_sat = 0;
            end
         end else begin
            ev_vld = 0;
         end
         for (int i = 0; i < NC; i++) begin
            if (g[i]) begin
               ptr = i;
               pend.push_back('{i, int'(req_addr[i*AW +: AW]), int'(req_neg[i]), cyc + 2});
            end
         end
      end
      cyc++;
   endtask

   task automatic cycle();
      logic [NC-1:0] mg;
      @(negedge clk);
      mg = model_grant();
      chk("req_ready", 32'(req_ready), 32'(mg));
      chk("rsp_valid", 32'(rsp_valid), ev_vld);
      chk("rsp_ch",    32'(rsp_ch),    ev_ch);
      chk("rsp_data",  32'(rsp_data),  ev_data);
      chk("rsp_sat",   32'(rsp_sat),   ev_sat);
      @(posedge clk);
      model_step(mg);
      last_g = mg;
      #1;
   endtask

   task automatic set_lane(input int i, input int a, input int n);
      req_valid[i] = 1'b1;
      req_addr[i*AW +: AW] = AW'(a);
      req_neg[i] = n[0];
   endtask

   task automatic lookup(input int i, input int a, input int n);
      set_lane(i, a, n);
      cycle();
      req_valid[i] = 1'b0;
      cycle();
   endtask

   task automatic wr(input int a, input int d);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = DW'(d);
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input int ch, input int d, input int s);
      chk({tag, "_vld"},  32'(rsp_valid), 1);
      chk({tag, "_ch"},   32'(rsp_ch),    ch);
      chk({tag, "_data"}, 32'(rsp_data),  d);
      chk({tag, "_sat"},  32'(rsp_sat),   s);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      req_valid = '1; req_addr = '0; req_neg = '0;
      cyc = 0; ptr = NC - 1; last_g = '0;
      ev_vld = 0; ev_ch = 0; ev_data = 0; ev_sat = 0;
      @(posedge clk);
      model_step('0);
      #1;
      cycle();                       // reset state, requests present but not granted
      rst_n = 1'b1; req_valid = '0;

      // Step 1: empty table reads zero
      lookup(0, 8'h37, 0);
      expect_rsp("t1", 0, 0, 0);

      // Step 2: plain and negated read of 0x1FF
      wr(8'h04, 9'h1FF);
      lookup(1, 8'h04, 0);
      expect_rsp("t2_pos", 1, 9'h1FF, 0);
      lookup(1, 8'h04, 1);
      expect_rsp("t2_neg", 1, 9'h001, 0);

      // Step 3: most-negative entry saturates on negation
      wr(8'h10, 9'h100);
      lookup(2, 8'h10, 1);
      expect_rsp("t3_neg", 2, 9'h0FF, 1);
      lookup(2, 8'h10, 0);
      expect_rsp("t3_pos", 2, 9'h100, 0);

      // Step 4: four lanes held for 8 cycles rotate 0,1,2,3,...
      lookup(3, 8'h37, 0);
      for (int i = 0; i < NC; i++) set_lane(i, 8'h04, 0);
      for (int k = 0; k < 10; k++) begin
         req_valid = (k < 8) ? '1 : '0;
         cycle();
         if (k >= 1 && k <= 8) begin
            chk("t4_vld", 32'(rsp_valid), 1);
            chk("t4_ch", 32'(rsp_ch), (k - 1) % NC);
         end
      end

      // Step 5: write blocks grants and keeps pointer; write-first bypass
      req_valid = '1; cfg_we = 1'b1; cfg_addr = 8'h55; cfg_wdata = 9'h0AA;
      #1 chk("t5_blocked", 32'(req_ready), 0);
      cycle();
      cfg_we = 1'b0;
      #1 chk("t5_ptr_held", 32'(req_ready), 1);
      cycle();
      req_valid = '0;
      cycle(); cycle();
      set_lane(3, 8'h22, 0);
      cycle();
      req_valid[3] = 1'b0;
      wr(8'h22, 9'h005);
      expect_rsp("t5_bypass", 3, 9'h005, 0);

      // Step 6: reset with lookups in flight
      req_valid = '0;
      set_lane(0, 8'h04, 0);
      set_lane(1, 8'h10, 0);
      cycle();
      req_valid[0] = 1'b0;
      cycle();
      req_valid = '0; rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("t6_drop0", 32'(rsp_valid), 0);
      cycle();
      chk("t6_drop1", 32'(rsp_valid), 0);
      for (int i = 0; i < NC; i++) set_lane(i, 8'h04, 0);
      cycle();
      req_valid = 4'b1110;
      cycle();
      expect_rsp("t6_lane0", 0, 0, 0);
      req_valid = 4'b1100;
      cycle();
      req_valid = 4'b1000;
      cycle();
      req_valid = '0;
      cycle(); cycle();

      // Random traffic over a small address window to provoke bypass and saturation cases
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         cfg_we = ($urandom_range(0, 3) == 0);
         cfg_addr = AW'($urandom_range(0, 7));
         cfg_wdata = ($urandom_range(0, 3) == 0) ? 9'h100 : DW'($urandom);
         for (int i = 0; i < NC; i++) begin
            if (!req_valid[i] || last_g[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
               req_neg[i] = 1'($urandom_range(0, 1));
            end
         end
         cycle();
      end
      rst_n = 1'b1; cfg_we = 1'b0; req_valid = '0;
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
